muxbit_arb: RTL and testbench
=============================

# muxbit_arb

Output-port arbiter and sequencer for the NoC 4-way bit-mux stage. It takes flit requests from the four next-hop inputs and picks one with round-robin priority. It then holds that choice for the whole packet, up to the tail flit. The held choice drives the one-hot `sel` and `override` buses that feed every `muxbit_wrap` slice of the output port. A configuration path can pin the port to one input. A watchdog frees the port if the owning input stalls.

## Interface
Parameters:
- `NEXTHOPWIDTH`, default 4. Number of requesters; equals the mux width and is fixed at 4 in this design.
- `TIMEOUT`, default 255. Number of consecutive stalled cycles that triggers forced release; range 1..255.

Ports:
- `clk` — in, 1. Single clock domain.
- `rst` — in, 1. Reset, asynchronous and active-low.
- `req` — in, 4. Per-input flit valid targeting this output port.
- `last` — in, 4. Per-input tail-flit marker, qualified by `req`.
- `out_ready` — in, 1. Downstream accepts a flit this cycle.
- `cfg_ovr_en` — in, 1. Enables static override routing.
- `cfg_ovr_idx` — in, 2. Input index that override routing pins the port to.
- `sel` — out, 4. One-hot mux select to `muxbit_wrap`, registered.
- `override` — out, 4. One-hot mux override to `muxbit_wrap`, registered.
- `gnt` — out, 4. Per-input flit-accepted strobe, combinational.
- `busy` — out, 1. Port is locked to an owner.
- `err_timeout` — out, 1. One-cycle pulse on watchdog release.

## Operation
- States:
  - IDLE: no owner.
  - LOCK: round-robin owner; drives `sel`.
  - OVR_LOCK: override owner; drives `override`.
- Internal registers:
  - `owner`, 2 bits.
  - `rr_ptr`, 2 bits.
  - `wd_cnt`, 8 bits.
- IDLE, with `cfg_ovr_en`=1:
  - If `req[cfg_ovr_idx]`=1, set `owner`=`cfg_ovr_idx` and go to OVR_LOCK.
  - All other requests are ignored.
- IDLE, with `cfg_ovr_en`=0:
  - Scan `req` starting at `rr_ptr`, then `rr_ptr`+1, and so on, mod 4.
  - The first set bit becomes `owner`; go to LOCK.
  - If no bit is set, stay in IDLE.
- `cfg_*` is sampled only in IDLE. A change while locked takes effect at the next packet boundary.
- Outputs by state:
  - LOCK: `sel`=onehot(`owner`), `override`=0.
  - OVR_LOCK: `override`=onehot(`owner`), `sel`=0.
  - IDLE: `sel`=0 and `override`=0.
- Transfer:
  - In either lock state, `gnt[owner]` = `req[owner]` & `out_ready`.
  - All other `gnt` bits are 0. `gnt` is always 0 in IDLE.
- Tail: a transfer with `last[owner]`=1 releases the port.
  - Next state is IDLE.
  - `rr_ptr` becomes `owner`+1 mod 4, but only when leaving LOCK. Leaving OVR_LOCK leaves `rr_ptr` unchanged.
- Watchdog:
  - In a lock state, `wd_cnt` increments on each cycle where `req[owner]`=0.
  - It clears on any cycle where `req[owner]`=1, and on entry to a lock state.
  - When `wd_cnt`=`TIMEOUT`-1 and `req[owner]`=0, the next state is IDLE. `err_timeout` pulses that same next cycle.
  - `rr_ptr` advances past `owner` as on a tail.
  - Stalls caused by `out_ready`=0 with `req[owner]`=1 never time out.
- Simultaneous tail and timeout cannot occur, because a tail requires `req[owner]`=1.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, `owner`=0, `rr_ptr`=0, `wd_cnt`=0, and `sel`, `override`, `gnt`, `busy`, `err_timeout` all 0.
- Reset is asynchronous. Asserting it mid-packet drops `sel`/`override` immediately; the remainder of the packet is lost by design.
- Arbitration latency:
  - `req` seen in IDLE at cycle N gives `sel`/`override` and `busy` valid at cycle N+1.
  - The first `gnt` is possible at N+1.
- The tail transfer occurs at cycle M. `sel`, `override`, `busy` are 0 at M+1. The earliest new grant is visible at M+2, so there is a one-cycle bubble between packets.
- A single-flit packet (`last` with the first flit) gives the sequence: lock at N+1, transfer at N+1, idle at N+2.
- `gnt` is combinational from `req`, `out_ready` and state. No combinational path exists from `cfg_*` to any output.

## Test plan
- **Reset:**
  - Stimulus: hold `rst`=0 with random inputs.
  - Required: all outputs 0. After release with `req`=0000, stay IDLE for 10 cycles with `busy`=0.
- **Round-robin fairness:**
  - Stimulus: `req`=1111 held continuously, `out_ready`=1, every flit `last`=1.
  - Required: grant order 0,1,2,3,0. `sel` goes 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle.
- **Packet lock:**
  - Stimulus: input 2 sends a 4-flit packet. Input 0 requests during flit 2. `out_ready` drops for 3 cycles mid-packet.
  - Required: `sel`=0100 throughout the packet. `gnt[2]` pulses exactly 4 times. `err_timeout`=0. After the tail, `sel`=0001.
- **Override:**
  - Stimulus: `cfg_ovr_en`=1, `cfg_ovr_idx`=3, `req`=1001.
  - Required: `override`=1000, `sel`=0000, input 0 never granted. Clearing `cfg_ovr_en` mid-packet has no effect until the tail; the next grant is then to input 0 via `sel`=0001.
- **Watchdog:**
  - Stimulus: `TIMEOUT`=4. Input 1 is granted, then drops `req` with no tail.
  - Required: exactly 4 stalled cycles, then `busy`=0 and one `err_timeout` pulse. Next `rr_ptr`=2, verified by `req`=1111 granting input 2.
- **Reset mid-packet:**
  - Stimulus: assert `rst` during a locked packet, asynchronously and between clock edges.
  - Required: `sel`=0 and `busy`=0 immediately. After release, `rr_ptr`=0 and the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/muxbit_arb.sv
// Output-port arbiter for the 4-way bit-mux stage: round-robin or pinned
// owner, held per packet, with a stall watchdog.
module muxbit_arb #(
  parameter int NEXTHOPWIDTH = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NEXTHOPWIDTH-1:0] req,
  input  logic [NEXTHOPWIDTH-1:0] last,
  input  logic                    out_ready,
  input  logic                    cfg_ovr_en,
  input  logic [1:0]              cfg_ovr_idx,
  output logic [NEXTHOPWIDTH-1:0] sel,
  output logic [NEXTHOPWIDTH-1:0] override,
  output logic [NEXTHOPWIDTH-1:0] gnt,
  output logic                    busy,
  output logic                    err_timeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK     = 2'd1,
    OVR_LOCK = 2'd2
  } state_e;

  localparam logic [7:0] WD_MAX = 8'(TIMEOUT - 1);
  localparam int         NW     = NEXTHOPWIDTH;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]      wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
  logic [NW-1:0]   sel_q, sel_d;
  logic [NW-1:0]   ovr_q, ovr_d;

  logic            locked;
  logic            own_req;
  logic            own_last;
  logic            xfer;
  logic            release_pkt;
  logic [NW-1:0]   own_oh;
  logic [2*NW-1:0] req2;
  logic [2*NW-1:0] rot_w;
  logic [NW-1:0]   rot;
  logic            rr_hit;
  logic [1:0]      rr_off;

  assign locked   = (state_q != IDLE);
  assign own_req  = req[owner_q];
  assign own_last = last[owner_q];
  assign xfer     = locked & own_req & out_ready;
  assign own_oh   = NW'(1) << owner_q;

  // Rotate so bit 0 is the input at rr_ptr; lowest set bit wins.
  assign req2 = {req, req};
  assign rot_w = req2 >> rr_ptr_q;
  assign rot = rot_w[NW-1:0];

  always_comb begin
    rr_hit = 1'b0;
    rr_off = 2'd0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rr_hit = 1'b1;
        rr_off = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    wd_cnt_d    = wd_cnt_q;
    err_d       = 1'b0;
    release_pkt = 1'b0;
    unique case (state_q)
      IDLE: begin
        wd_cnt_d = 8'd0;
        if (cfg_ovr_en) begin
          if (req[cfg_ovr_idx]) begin
            owner_d = cfg_ovr_idx;
            state_d = OVR_LOCK;
          end
        end else if (rr_hit) begin
          owner_d = rr_ptr_q + rr_off;
          state_d = LOCK;
        end
      end
      LOCK, OVR_LOCK: begin
        if (own_req) begin
          wd_cnt_d = 8'd0;
          if (xfer && own_last) begin
            release_pkt = 1'b1;
          end
        end else if (wd_cnt_q == WD_MAX) begin
          wd_cnt_d    = 8'd0;
          err_d       = 1'b1;
          release_pkt = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
        if (release_pkt) begin
          state_d = IDLE;
          if (state_q == LOCK) begin
            rr_ptr_d = owner_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Mux controls are registered from the next owner so they are glitch-free.
  always_comb begin
    sel_d = '0;
    ovr_d = '0;
    unique case (1'b1)
      (state_d == LOCK):     sel_d = NW'(1) << owner_d;
      (state_d == OVR_LOCK): ovr_d = NW'(1) << owner_d;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 2'd0;
      rr_ptr_q <= 2'd0;
      wd_cnt_q <= 8'd0;
      err_q    <= 1'b0;
      sel_q    <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
      sel_q    <= sel_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sel         = sel_q;
  assign override    = ovr_q;
  assign gnt         = xfer ? own_oh : '0;
  assign busy        = locked;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_muxbit_arb.sv
// Self-checking bench for muxbit_arb: directed scenarios plus random
// traffic against a packet-level reference model.
module tb_muxbit_arb;

  localparam int TO = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic       cfg_ovr_en;
  logic [1:0] cfg_ovr_idx;
  logic [3:0] sel;
  logic [3:0] override;
  logic [3:0] gnt;
  logic       busy;
  logic       err_timeout;

  int n_cmp;
  int n_err;

  // Reference model: who owns the port and how.
  bit m_busy;
  bit m_ovr;
  int m_owner;
  int m_rr;
  int m_stall;
  bit m_err;

  muxbit_arb #(.NEXTHOPWIDTH(4), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .last(last),
    .out_ready(out_ready),
    .cfg_ovr_en(cfg_ovr_en),
    .cfg_ovr_idx(cfg_ovr_idx),
    .sel(sel),
    .override(override),
    .gnt(gnt),
    .busy(busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] dut_vec;
  assign dut_vec = {sel, override, gnt, busy, err_timeout};

  task automatic model_reset();
    m_busy  = 0;
    m_ovr   = 0;
    m_owner = 0;
    m_rr    = 0;
    m_stall = 0;
    m_err   = 0;
  endtask

  // Advance the model one clock using the inputs currently driven.
  task automatic model_next();
    bit found;
    m_err = 0;
    if (!m_busy) begin
      if (cfg_ovr_en) begin
        if (req[cfg_ovr_idx]) begin
          m_busy = 1; m_ovr = 1;
          m_owner = int'(cfg_ovr_idx); m_stall = 0;
        end
      end else begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          if (!found && req[(m_rr + k) % 4]) begin
            found = 1; m_busy = 1; m_ovr = 0;
            m_owner = (m_rr + k) % 4; m_stall = 0;
          end
        end
      end
    end else if (req[m_owner]) begin
      m_stall = 0;
      if (out_ready && last[m_owner]) begin
        m_busy = 0;
        if (!m_ovr) m_rr = (m_owner + 1) % 4;
      end
    end else begin
      m_stall++;
      if (m_stall == TO) begin
        m_busy = 0; m_err = 1; m_stall = 0;
        if (!m_ovr) m_rr = (m_owner + 1) % 4;
      end
    end
  endtask

  function automatic logic [13:0] exp_vec();
    logic [3:0] oh, s, o, g;
    oh = 4'b0001 << m_owner;
    s = (m_busy && !m_ovr) ? oh : 4'b0;
    o = (m_busy && m_ovr) ? oh : 4'b0;
    g = (m_busy && req[m_owner] && out_ready) ? oh : 4'b0;
    return {s, o, g, m_busy, m_err};
  endfunction

  task automatic drive(input logic [3:0] r, input logic [3:0] l,
                       input logic rdy, input logic en,
                       input logic [1:0] idx);
    req = r; last = l; out_ready = rdy;
    cfg_ovr_en = en; cfg_ovr_idx = idx;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    model_next();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom));
      n_cmp++;
      if (dut_vec !== 14'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, dut_vec, 14'b0);
      end
      @(posedge clk);
      @(negedge clk);
    end
    drive(4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      drive(4'b0, 4'b0, 1'b1, 1'b0, 2'd0);
      n_cmp++;
      if (busy !== 1'b0 || dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, dut_vec,
                 exp_vec());
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int want[5] = '{0, 1, 2, 3, 0};
    logic [3:0] sw[10] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                           4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    for (int i = 0; i < 10; i++) begin
      drive(4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0);
      n_cmp++;
      if (dut_vec !== exp_vec() || sel !== sw[i]) begin
        n_err++;
        $display("FAIL rr_seq cyc=%0d got=%b exp=%b sel_exp=%b", i, dut_vec,
                 exp_vec(), sw[i]);
      end
      for (int k = 0; k < 4; k++) if (gnt[k]) order.push_back(k);
      step();
    end
    n_cmp++;
    if (order.size() != 5) begin
      n_err++;
      $display("FAIL rr_count got=%0d exp=5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (order[k] != want[k]) begin
          n_err++;
          $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, order[k],
                   want[k]);
        end
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [3:0] tr[11] = '{4'b0100, 4'b0100, 4'b0101, 4'b0101, 4'b0101,
                           4'b0101, 4'b0101, 4'b0101, 4'b0001, 4'b0001,
                           4'b0001};
    logic [3:0] tl[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                           4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000,
                           4'b0001};
    logic tk[11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    int g2 = 0;
    int errs = 0;
    for (int i = 0; i < 11; i++) begin
      drive(tr[i], tl[i], tk[i], 1'b0, 2'd0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL lock_model cyc=%0d got=%b exp=%b", i, dut_vec,
                 exp_vec());
      end
      if (i >= 1 && i <= 7) begin
        n_cmp++;
        if (sel !== 4'b0100) begin
          n_err++;
          $display("FAIL lock_sel cyc=%0d got=%b exp=0100", i, sel);
        end
      end
      if (gnt[2]) g2++;
      if (err_timeout) errs++;
      if (i == 9) begin
        n_cmp++;
        if (sel !== 4'b0001) begin
          n_err++;
          $display("FAIL lock_next got=%b exp=0001", sel);
        end
      end
      step();
    end
    n_cmp++;
    if (g2 != 4 || errs != 0) begin
      n_err++;
      $display("FAIL lock_gnt2 got=%0d/%0d exp=4/0", g2, errs);
    end
  endtask

  task automatic test_override();
    logic [3:0] tr[7] = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
                          4'b0001, 4'b0001};
    logic [3:0] tl[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000,
                          4'b0000, 4'b0001};
    logic te[7] = '{1, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      drive(tr[i], tl[i], 1'b1, te[i], 2'd3);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL ovr_model cyc=%0d got=%b exp=%b", i, dut_vec,
                 exp_vec());
      end
      if (i >= 1 && i <= 4) begin
        n_cmp++;
        if (override !== 4'b1000 || sel !== 4'b0000) begin
          n_err++;
          $display("FAIL ovr_bus cyc=%0d got=%b/%b exp=1000/0000", i,
                   override, sel);
        end
      end
      if (i <= 5) begin
        n_cmp++;
        if (gnt[0] !== 1'b0) begin
          n_err++;
          $display("FAIL ovr_gnt0 cyc=%0d got=%b exp=0", i, gnt[0]);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if (sel !== 4'b0001 || gnt !== 4'b0001) begin
          n_err++;
          $display("FAIL ovr_after got=%b/%b exp=0001/0001", sel, gnt);
        end
      end
      step();
    end
  endtask

  task automatic test_watchdog();
    logic [3:0] tr[11] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                           4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111,
                           4'b1111};
    logic [3:0] tl[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                           4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                           4'b0100};
    int stalled = 0;
    int pulses = 0;
    for (int i = 0; i < 11; i++) begin
      drive(tr[i], tl[i], 1'b1, 1'b0, 2'd0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL wd_model cyc=%0d got=%b exp=%b", i, dut_vec,
                 exp_vec());
      end
      if (i >= 2 && i <= 7 && busy) stalled++;
      if (err_timeout) pulses++;
      if (i == 9) begin
        n_cmp++;
        if (gnt !== 4'b0100) begin
          n_err++;
          $display("FAIL wd_rrptr got=%b exp=0100", gnt);
        end
      end
      step();
    end
    n_cmp++;
    if (stalled != TO || pulses != 1) begin
      n_err++;
      $display("FAIL wd_count got=%0d/%0d exp=%0d/1", stalled, pulses, TO);
    end
  endtask

  task automatic test_reset_mid_packet();
    drive(4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0);
    step();
    drive(4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0);
    n_cmp++;
    if (sel !== 4'b0100 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre got=%b/%b exp=0100/1", sel, busy);
    end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (sel !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async got=%b/%b exp=0000/0", sel, busy);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(4'b1010, 4'b0000, 1'b1, 1'b0, 2'd0);
    step();
    drive(4'b1010, 4'b0010, 1'b1, 1'b0, 2'd0);
    n_cmp++;
    if (sel !== 4'b0010 || gnt !== 4'b0010 || dut_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL rstmid_first got=%b exp=%b", dut_vec, exp_vec());
    end
    step();
  endtask

  task automatic test_random();
    logic en;
    logic [1:0] idx;
    en = 1'b0;
    idx = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = 1'($urandom);
      if ($urandom_range(0, 19) == 0) idx = 2'($urandom);
      drive(4'($urandom) & 4'($urandom | 32'h5), 4'($urandom) & 4'($urandom),
            ($urandom_range(0, 3) != 0), en, idx);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    req = '0; last = '0; out_ready = 1'b0;
    cfg_ovr_en = 1'b0; cfg_ovr_idx = 2'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_override();
    test_watchdog();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
